// File: rtl/touch_i2c_responder.sv
// I2C target emulating the touch controller register map: one status byte and a
// four-byte touch-point record behind a 16-bit auto-incrementing pointer.
module touch_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR       = 7'h14,
  parameter logic [15:0] STATE_REG_ADDR = 16'h814E,
  parameter logic [15:0] LOC_START_ADDR = 16'h8150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        touch_valid,
  input  logic [15:0] touch_x,
  input  logic [15:0] touch_y,
  output logic        busy,
  output logic        touch_drop
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DEV     = 4'd1;
  localparam logic [3:0] S_ACK_DEV = 4'd2;
  localparam logic [3:0] S_ADDR_H  = 4'd3;
  localparam logic [3:0] S_ACK_AH  = 4'd4;
  localparam logic [3:0] S_ADDR_L  = 4'd5;
  localparam logic [3:0] S_ACK_AL  = 4'd6;
  localparam logic [3:0] S_WDATA   = 4'd7;
  localparam logic [3:0] S_ACK_W   = 4'd8;
  localparam logic [3:0] S_RDATA   = 4'd9;
  localparam logic [3:0] S_RACK    = 4'd10;
  localparam logic [3:0] S_IGNORE  = 4'd11;

  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [15:0] ptr, ptr_inc;
  logic        rw, ack_bit;
  logic        ready, ready_cleared, clear_w;
  logic [15:0] pt_x, pt_y;
  logic [7:0]  rd_cur, rd_next;

  // Synchronizers carry no reset so a mid-transaction reset cannot fake a START.
  always_ff @(posedge clk) begin
    {scl_d, scl_s2, scl_s1} <= {scl_s2, scl_s1, scl};
    {sda_d, sda_s2, sda_s1} <= {sda_s2, sda_s1, sda_in};
  end

  always_comb begin
    scl_rise  = scl_s2 & ~scl_d;
    scl_fall  = ~scl_s2 & scl_d;
    start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  end

  function automatic logic [7:0] reg_byte(input logic [15:0] a, input logic rdy,
                                          input logic [15:0] x, input logic [15:0] y);
    logic [15:0] off;
    off      = a - LOC_START_ADDR;
    reg_byte = 8'h00;
    if (a == STATE_REG_ADDR) begin
      reg_byte = {rdy, 6'b000000, rdy};
    end else begin
      case (off)
        16'd0:   reg_byte = x[7:0];
        16'd1:   reg_byte = x[15:8];
        16'd2:   reg_byte = y[7:0];
        16'd3:   reg_byte = y[15:8];
        default: reg_byte = 8'h00;
      endcase
    end
  endfunction

  always_comb begin
    ptr_inc = ptr + 16'd1;
    rd_cur  = reg_byte(ptr, ready, pt_x, pt_y);
    rd_next = reg_byte(ptr_inc, ready, pt_x, pt_y);
    clear_w = (state == S_WDATA) && scl_fall && (bit_cnt == 4'd8) && (ptr == STATE_REG_ADDR);
    ready_cleared = ready & ~clear_w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_bit <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else if (start_det) begin
      state   <= S_DEV;
      bit_cnt <= '0;
      busy    <= 1'b1;
    end else if (stop_det) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      sda_oe <= 1'b0;
    end else if (scl_rise) begin
      case (state)
        S_DEV, S_ADDR_H, S_ADDR_L, S_WDATA: begin
          if (bit_cnt < 4'd8) begin
            shreg   <= {shreg[6:0], sda_s2};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_RACK:  ack_bit <= sda_s2;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        S_DEV: begin
          if (bit_cnt == 4'd8) begin
            if (shreg[7:1] == DEV_ADDR) begin
              state  <= S_ACK_DEV;
              sda_oe <= 1'b1;
              rw     <= shreg[0];
            end else begin
              state <= S_IGNORE;
            end
          end
        end
        S_ACK_DEV: begin
          bit_cnt <= '0;
          if (rw) begin
            // The read byte is snapshotted here; later captures cannot disturb it.
            shreg   <= rd_cur;
            sda_oe  <= ~rd_cur[7];
            bit_cnt <= 4'd1;
            state   <= S_RDATA;
          end else begin
            sda_oe <= 1'b0;
            state  <= S_ADDR_H;
          end
        end
        S_ADDR_H: begin
          if (bit_cnt == 4'd8) begin
            ptr[15:8] <= shreg;
            sda_oe    <= 1'b1;
            state     <= S_ACK_AH;
          end
        end
        S_ACK_AH: begin
          sda_oe  <= 1'b0;
          bit_cnt <= '0;
          state   <= S_ADDR_L;
        end
        S_ADDR_L: begin
          if (bit_cnt == 4'd8) begin
            ptr[7:0] <= shreg;
            sda_oe   <= 1'b1;
            state    <= S_ACK_AL;
          end
        end
        S_ACK_AL: begin
          sda_oe  <= 1'b0;
          bit_cnt <= '0;
          state   <= S_WDATA;
        end
        S_WDATA: begin
          if (bit_cnt == 4'd8) begin
            sda_oe <= 1'b1;
            state  <= S_ACK_W;
          end
        end
        S_ACK_W: begin
          sda_oe  <= 1'b0;
          bit_cnt <= '0;
          ptr     <= ptr_inc;
          state   <= S_WDATA;
        end
        S_RDATA: begin
          if (bit_cnt == 4'd8) begin
            sda_oe <= 1'b0;
            state  <= S_RACK;
          end else begin
            sda_oe  <= ~shreg[6];
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_RACK: begin
          if (!ack_bit) begin
            ptr     <= ptr_inc;
            shreg   <= rd_next;
            sda_oe  <= ~rd_next[7];
            bit_cnt <= 4'd1;
            state   <= S_RDATA;
          end else begin
            sda_oe <= 1'b0;
            state  <= S_IGNORE;
          end
        end
        default: sda_oe <= 1'b0;
      endcase
    end
  end

  // A clear-write landing with touch_valid is applied first, so the new point is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready      <= 1'b0;
      pt_x       <= '0;
      pt_y       <= '0;
      touch_drop <= 1'b0;
    end else begin
      touch_drop <= 1'b0;
      ready      <= ready_cleared;
      if (touch_valid) begin
        if (ready_cleared) begin
          touch_drop <= 1'b1;
        end else begin
          pt_x  <= touch_x;
          pt_y  <= touch_y;
          ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_touch_i2c_responder.sv
// Bench for touch_i2c_responder: bit-banged I2C master, directed scenarios and
// random transactions checked against a register-map model.
module tb_touch_i2c_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe, busy, touch_drop;
  logic        touch_valid = 1'b0;
  logic [15:0] touch_x = '0, touch_y = '0;

  int unsigned n_vec = 0, n_err = 0;
  int unsigned drop_cnt = 0, m_drops = 0;
  bit          oe_seen = 1'b0;
  bit          rst_hit = 1'b0;

  bit          m_ready = 1'b0;
  logic [15:0] m_x = '0, m_y = '0, m_ptr = '0;

  assign sda_line = sda_m & ~sda_oe;

  touch_i2c_responder #(
    .DEV_ADDR(7'h14), .STATE_REG_ADDR(16'h814E), .LOC_START_ADDR(16'h8150)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .touch_valid(touch_valid), .touch_x(touch_x), .touch_y(touch_y),
    .busy(busy), .touch_drop(touch_drop)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (touch_drop) drop_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_byte(input logic [15:0] a);
    if (a == 16'h814E) return m_ready ? 8'h81 : 8'h00;
    if (a == 16'h8150) return m_x[7:0];
    if (a == 16'h8151) return m_x[15:8];
    if (a == 16'h8152) return m_y[7:0];
    if (a == 16'h8153) return m_y[15:8];
    return 8'h00;
  endfunction

  task automatic model_touch(input logic [15:0] x, input logic [15:0] y);
    if (m_ready) m_drops++;
    else begin
      m_x = x; m_y = y; m_ready = 1'b1;
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clk_wait(5);
    scl = 1'b1;   clk_wait(10);
    sda_m = 1'b0; clk_wait(10);
    scl = 1'b0;   clk_wait(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clk_wait(5);
    scl = 1'b1;   clk_wait(10);
    sda_m = 1'b1; clk_wait(10);
  endtask

  // One SCL period; with pulse set, touch_valid lands on the clk where the fall is seen.
  task automatic bit_cycle(input logic b, output logic s, input bit pulse);
    sda_m = b; clk_wait(10);
    scl = 1'b1; clk_wait(10);
    s = sda_line;
    scl = 1'b0;
    if (pulse) begin
      @(posedge clk); @(posedge clk); #1 touch_valid = 1'b1;
      @(posedge clk); #1 touch_valid = 1'b0;
      clk_wait(2);
    end else begin
      clk_wait(5);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked, input bit pulse);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s, pulse && (i == 0));
    bit_cycle(1'b1, s, 1'b0);
    acked = ~s;
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] b, input int rst_bit);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      if (i == rst_bit) begin
        rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        m_ready = 1'b0; m_x = '0; m_y = '0; m_ptr = '0;
        rst_hit = 1'b1;
      end
      bit_cycle(1'b1, s, 1'b0);
      b[i] = s;
    end
    bit_cycle(nack, s, 1'b0);
  endtask

  task automatic send_ptr(input logic [15:0] a);
    logic ack;
    write_byte(8'h28, ack, 1'b0); check("dev_w_ack", ack, 1'b1);
    write_byte(a[15:8], ack, 1'b0); check("addr_h_ack", ack, 1'b1);
    write_byte(a[7:0], ack, 1'b0);  check("addr_l_ack", ack, 1'b1);
    m_ptr = a;
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input logic [31:0] data,
                          input bit coinc, input logic [15:0] cx, input logic [15:0] cy);
    logic ack;
    i2c_start();
    check("busy_start", busy, 1'b1);
    send_ptr(a);
    for (int k = 0; k < n; k++) begin
      bit last_c;
      last_c = coinc && (k == n - 1);
      touch_x = cx; touch_y = cy;
      write_byte(data[8*k +: 8], ack, last_c);
      check("wdata_ack", ack, 1'b1);
      if (m_ptr == 16'h814E) m_ready = 1'b0;
      if (last_c) model_touch(cx, cy);
      m_ptr = m_ptr + 16'd1;
    end
    i2c_stop();
    check("busy_stop", busy, 1'b0);
  endtask

  task automatic do_read(input bit set_p, input logic [15:0] a, input int n,
                         input int rst_byte, input int rst_bit);
    logic ack;
    logic [7:0] b;
    rst_hit = 1'b0;
    i2c_start();
    check("busy_start", busy, 1'b1);
    if (set_p) begin
      send_ptr(a);
      i2c_start();
    end
    write_byte(8'h29, ack, 1'b0);
    check("dev_r_ack", ack, 1'b1);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b, (k == rst_byte) ? rst_bit : -1);
      if (!rst_hit) begin
        check($sformatf("rdata@%04h", m_ptr), b, m_byte(m_ptr));
        if (k != n - 1) m_ptr = m_ptr + 16'd1;
      end
    end
    i2c_stop();
    check("busy_stop", busy, 1'b0);
  endtask

  task automatic touch_pulse(input logic [15:0] x, input logic [15:0] y);
    logic exp_drop;
    exp_drop = m_ready;
    touch_x = x; touch_y = y; touch_valid = 1'b1;
    @(posedge clk); #1 touch_valid = 1'b0;
    check("touch_drop", touch_drop, exp_drop);
    model_touch(x, y);
    clk_wait(1);
    check("touch_drop_end", touch_drop, 1'b0);
  endtask

  task automatic bad_dev(input logic [6:0] addr, input logic rwb);
    logic ack;
    i2c_start();
    oe_seen = 1'b0;
    write_byte({addr, rwb}, ack, 1'b0);
    check("bad_dev_nack", ack, 1'b0);
    check("bad_dev_oe", oe_seen, 1'b0);
    i2c_stop();
  endtask

  function automatic logic [15:0] pick_addr();
    logic [31:0] r;
    r = $urandom;
    case (r[1:0])
      2'd0: return 16'h814E;
      2'd1: return 16'h8150 + {14'd0, r[3:2]};
      2'd2: return 16'h814C + {13'd0, r[6:4]};
      default: return r[8] ? 16'hFFFE + {15'd0, r[9]} : r[31:16];
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    logic [6:0]  badaddr;
    int unsigned d0;

    clk_wait(5);
    rst_n = 1'b1;
    clk_wait(2);
    check("reset_sda_oe", sda_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_drop", touch_drop, 1'b0);
    do_read(1'b1, 16'h814E, 1, -1, -1);

    // Clear-write with ready set.
    touch_pulse(16'd123, 16'd456);
    do_write(16'h814E, 1, 32'h0, 1'b0, '0, '0);
    check("ready_cleared", m_ready, 1'b0);
    do_read(1'b1, 16'h814E, 1, -1, -1);

    // Point read after a capture.
    touch_pulse(16'd400, 16'd240);
    do_read(1'b1, 16'h8150, 4, -1, -1);
    do_read(1'b1, 16'h814E, 1, -1, -1);

    // Foreign device address; pointer and ready must survive.
    bad_dev(7'h15, 1'b0);
    do_read(1'b0, 16'h0, 1, -1, -1);

    // Second capture without clear is dropped exactly once.
    d0 = drop_cnt;
    touch_pulse(16'd7, 16'd9);
    clk_wait(2);
    check("drop_once", drop_cnt - d0, 1);
    do_read(1'b1, 16'h8150, 4, -1, -1);

    // Clear-write and capture on the same clk.
    do_write(16'h814E, 1, 32'h0, 1'b1, 16'd1, 16'd2);
    check("coinc_ready", m_ready, 1'b1);
    do_read(1'b1, 16'h8150, 4, -1, -1);
    do_read(1'b1, 16'h814E, 1, -1, -1);

    // Reset during the second read byte, then normal operation.
    do_read(1'b1, 16'h8150, 4, 1, 6);
    do_read(1'b1, 16'h814E, 1, -1, -1);
    touch_pulse(16'hBEEF, 16'h1234);
    do_read(1'b1, 16'h8150, 4, -1, -1);

    for (int it = 0; it < 25; it++) begin
      r = $urandom;
      case (r[2:0])
        3'd0, 3'd1: touch_pulse(r[31:16], r[15:0] ^ 16'h5A5A);
        3'd2: do_write(pick_addr(), 1 + int'($urandom_range(0, 2)), $urandom,
                       r[3] & r[4], r[31:16], r[23:8]);
        3'd3, 3'd4: do_read(1'b1, pick_addr(), 1 + int'($urandom_range(0, 2)), -1, -1);
        3'd5: do_read(1'b0, 16'h0, 1 + int'($urandom_range(0, 1)), -1, -1);
        default: begin
          badaddr = r[31:25];
          if (badaddr == 7'h14) badaddr = 7'h15;
          bad_dev(badaddr, r[5]);
        end
      endcase
    end

    clk_wait(3);
    check("drop_total", drop_cnt, m_drops);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
